// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the kernel memory bridge: FSM encodings, ready pulse value,
// and the byte-address to cache index/tag split.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_RESP      = 3'd1,
    RD_MISS_REQ  = 3'd2,
    RD_MISS_WAIT = 3'd3,
    WR_REQ       = 3'd4,
    WR_WAIT      = 3'd5,
    WR_RESP      = 3'd6
  } cache_state_t;

  localparam logic [63:0] READY_VAL = 64'd1;

  // Word index lives just above the two byte-offset bits.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int index_wid);
    return (addr >> 2) & ((64'd1 << index_wid) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int index_wid,
                                           input int tag_wid);
    return (addr >> (index_wid + 2)) & ((64'd1 << tag_wid) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_word_cache_array.sv
// Line storage for the word cache: data/tag/valid, combinational read, one write port.
// Read data is same-cycle; writes land at the clock edge; reset clears only the valid bits.
// No backpressure: a write is accepted every cycle it is enabled.
module mem_word_cache_array #(
  parameter int INDEX_WID = 8,
  parameter int TAG_WID   = 22,
  parameter int DATA_WID  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INDEX_WID-1:0] rd_index,
  output logic                 rd_valid,
  output logic [TAG_WID-1:0]   rd_tag,
  output logic [DATA_WID-1:0]  rd_data,
  input  logic                 we,
  input  logic [INDEX_WID-1:0] wr_index,
  input  logic [TAG_WID-1:0]   wr_tag,
  input  logic [DATA_WID-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_WID;

  logic [LINES-1:0]    valid_q;
  logic [TAG_WID-1:0]  tag_q  [LINES];
  logic [DATA_WID-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/mem_word_cache.sv
// Direct-mapped write-through word cache; optional hit/miss counters under MEM_WORD_CACHE_STATS_EN.
// Hit returns 1 cycle after enable, miss after downstream latency + 2; writes complete 1 cycle after ack.
// No backpressure: enables arriving while busy are dropped and flagged on sticky proto_err.
module mem_word_cache
  import mem_bridge_pkg::*;
#(
  parameter int INDEX_WID = 8,
  parameter int TAG_WID   = 22,
  parameter int DATA_WID  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                up_read_enable,
  input  logic [63:0]         up_read_addr,
  output logic [63:0]         up_read_ready,
  output logic [DATA_WID-1:0] up_read_data,
  input  logic                up_write_enable,
  input  logic [63:0]         up_write_addr,
  input  logic [DATA_WID-1:0] up_write_data,
  output logic [63:0]         up_write_ready,
  output logic                mem_rd_req,
  output logic [63:0]         mem_rd_addr,
  input  logic                mem_rd_valid,
  input  logic [DATA_WID-1:0] mem_rd_data,
  output logic                mem_wr_req,
  output logic [63:0]         mem_wr_addr,
  output logic [DATA_WID-1:0] mem_wr_data,
  input  logic                mem_wr_ack,
  output logic                proto_err,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  cache_state_t state;
  logic [63:0]  rd_addr;
  logic         pend_rd;

  logic [63:0]          lk_addr;
  logic [INDEX_WID-1:0] lk_index;
  logic [TAG_WID-1:0]   lk_tag;
  logic                 lk_go;
  logic                 lk_hit;
  logic                 line_valid;
  logic [TAG_WID-1:0]   line_tag;
  logic [DATA_WID-1:0]  line_data;

  logic                 arr_we;
  logic [INDEX_WID-1:0] arr_index;
  logic [TAG_WID-1:0]   arr_tag;
  logic [DATA_WID-1:0]  arr_data;

  // A pending read is looked up from WR_RESP exactly as a fresh IDLE read would be.
  assign lk_addr  = (state == WR_RESP) ? rd_addr : up_read_addr;
  assign lk_index = INDEX_WID'(addr_index(lk_addr, INDEX_WID));
  assign lk_tag   = TAG_WID'(addr_tag(lk_addr, INDEX_WID, TAG_WID));
  assign lk_go    = (state == IDLE && up_read_enable && !up_write_enable) ||
                    (state == WR_RESP && pend_rd);
  assign lk_hit   = line_valid && (line_tag == lk_tag);

  always_comb begin
    arr_we    = 1'b0;
    arr_index = INDEX_WID'(addr_index(up_write_addr, INDEX_WID));
    arr_tag   = TAG_WID'(addr_tag(up_write_addr, INDEX_WID, TAG_WID));
    arr_data  = up_write_data;
    if (state == IDLE && up_write_enable) begin
      arr_we = 1'b1;
    end else if (state == RD_MISS_WAIT && mem_rd_valid) begin
      arr_we    = 1'b1;
      arr_index = INDEX_WID'(addr_index(rd_addr, INDEX_WID));
      arr_tag   = TAG_WID'(addr_tag(rd_addr, INDEX_WID, TAG_WID));
      arr_data  = mem_rd_data;
    end
  end

  mem_word_cache_array #(
    .INDEX_WID (INDEX_WID),
    .TAG_WID   (TAG_WID),
    .DATA_WID  (DATA_WID)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (lk_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (arr_we),
    .wr_index (arr_index),
    .wr_tag   (arr_tag),
    .wr_data  (arr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rd_addr        <= '0;
      pend_rd        <= 1'b0;
      up_read_ready  <= '0;
      up_read_data   <= '0;
      up_write_ready <= '0;
      mem_rd_req     <= 1'b0;
      mem_rd_addr    <= '0;
      mem_wr_req     <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= '0;
      proto_err      <= 1'b0;
    end else begin
      up_read_ready  <= '0;
      up_write_ready <= '0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;

      if (state != IDLE && (up_read_enable || up_write_enable)) begin
        proto_err <= 1'b1;
      end

      if (lk_go) begin
        rd_addr <= lk_addr;
        pend_rd <= 1'b0;
        if (lk_hit) begin
          up_read_data  <= line_data;
          up_read_ready <= READY_VAL;
          state         <= RD_RESP;
        end else begin
          mem_rd_req  <= 1'b1;
          mem_rd_addr <= {lk_addr[63:2], 2'b00};
          state       <= RD_MISS_REQ;
        end
      end else begin
        case (state)
          IDLE: begin
            if (up_write_enable) begin
              mem_wr_req  <= 1'b1;
              mem_wr_addr <= {up_write_addr[63:2], 2'b00};
              mem_wr_data <= up_write_data;
              pend_rd     <= up_read_enable;
              rd_addr     <= up_read_addr;
              state       <= WR_REQ;
            end
          end
          RD_RESP:     state <= IDLE;
          RD_MISS_REQ: state <= RD_MISS_WAIT;
          RD_MISS_WAIT: begin
            if (mem_rd_valid) begin
              up_read_data  <= mem_rd_data;
              up_read_ready <= READY_VAL;
              state         <= RD_RESP;
            end
          end
          WR_REQ: state <= WR_WAIT;
          WR_WAIT: begin
            if (mem_wr_ack) begin
              up_write_ready <= READY_VAL;
              state          <= WR_RESP;
            end
          end
          WR_RESP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MEM_WORD_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lk_go && lk_hit && hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
      if (state == RD_MISS_WAIT && mem_rd_valid && miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_mem_word_cache.sv
// Directed bench for mem_word_cache: a per-operation loop plays host memory and records
// request/ready timing, then immediate assertions compare against hand-derived values.
module tb_mem_word_cache;

  localparam int OP_CYCLES = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        up_read_enable;
  logic [63:0] up_read_addr;
  logic [63:0] up_read_ready;
  logic [31:0] up_read_data;
  logic        up_write_enable;
  logic [63:0] up_write_addr;
  logic [31:0] up_write_data;
  logic [63:0] up_write_ready;
  logic        mem_rd_req;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [63:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        proto_err;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  int          n_rd_req, n_wr_req, rd_rdy_cnt, wr_rdy_cnt, rd_rdy_cycle, wr_rdy_cycle;
  logic [63:0] rd_req_addr, wr_req_addr;
  logic [31:0] wr_req_data, rd_dat;
  int          late_rdy;

  always #5 clk = ~clk;

  mem_word_cache dut (
    .clk             (clk),
    .reset           (reset),
    .up_read_enable  (up_read_enable),
    .up_read_addr    (up_read_addr),
    .up_read_ready   (up_read_ready),
    .up_read_data    (up_read_data),
    .up_write_enable (up_write_enable),
    .up_write_addr   (up_write_addr),
    .up_write_data   (up_write_data),
    .up_write_ready  (up_write_ready),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .mem_wr_req      (mem_wr_req),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ack      (mem_wr_ack),
    .proto_err       (proto_err),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle c counts negedges after the enable; memory answers rd_lat/ack_lat cycles after
  // seeing a request. inj_cycle > 0 fires a stray read enable on that cycle.
  task automatic op(input logic rd, input logic [63:0] ra, input logic wr,
                    input logic [63:0] wa, input logic [31:0] wd, input logic [31:0] mem_word,
                    input int rd_lat, input int ack_lat, input int inj_cycle);
    int rd_at;
    int ack_at;
    rd_at = -1; ack_at = -1;
    n_rd_req = 0; n_wr_req = 0; rd_rdy_cnt = 0; wr_rdy_cnt = 0;
    rd_rdy_cycle = -1; wr_rdy_cycle = -1;
    rd_req_addr = '0; wr_req_addr = '0; wr_req_data = '0; rd_dat = '0;
    up_read_enable = rd; up_read_addr = ra;
    up_write_enable = wr; up_write_addr = wa; up_write_data = wd;
    for (int c = 1; c <= OP_CYCLES; c++) begin
      @(negedge clk);
      up_read_enable = 1'b0; up_write_enable = 1'b0;
      mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
      if (mem_rd_req) begin
        n_rd_req++; rd_req_addr = mem_rd_addr; rd_at = c + rd_lat;
      end
      if (mem_wr_req) begin
        n_wr_req++; wr_req_addr = mem_wr_addr; wr_req_data = mem_wr_data; ack_at = c + ack_lat;
      end
      if (up_read_ready != 64'd0) begin
        rd_rdy_cnt++; rd_rdy_cycle = c; rd_dat = up_read_data;
      end
      if (up_write_ready != 64'd0) begin
        wr_rdy_cnt++; wr_rdy_cycle = c;
      end
      if (c == rd_at) begin
        mem_rd_valid = 1'b1; mem_rd_data = mem_word;
      end
      if (c == ack_at) mem_wr_ack = 1'b1;
      if (c == inj_cycle) begin
        up_read_enable = 1'b1; up_read_addr = 64'h900;
      end
    end
    mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; up_read_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    up_read_enable = 1'b0; up_read_addr = '0;
    up_write_enable = 1'b0; up_write_addr = '0; up_write_data = '0;
    mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_rd_ready", up_read_ready, 64'd0);
    check("rst_wr_ready", up_write_ready, 64'd0);
    check("rst_rd_data", {32'd0, up_read_data}, 64'd0);
    check("rst_mem_reqs", {62'd0, mem_rd_req, mem_wr_req}, 64'd0);
    check("rst_proto_err", {63'd0, proto_err}, 64'd0);
    check("rst_counts", {hit_count, miss_count}, 64'd0);

    // Cold miss with 3-cycle memory latency: ready at 3 + 2 = 5.
    op(1'b1, 64'h100, 1'b0, '0, '0, 32'hDEADBEEF, 3, 0, -1);
    check("miss_nreq", n_rd_req, 1);
    check("miss_addr", rd_req_addr, 64'h100);
    check("miss_rdy_cnt", rd_rdy_cnt, 1);
    check("miss_rdy_cycle", rd_rdy_cycle, 5);
    check("miss_data", {32'd0, rd_dat}, 64'hDEADBEEF);

    op(1'b1, 64'h102, 1'b0, '0, '0, 32'h0, 3, 0, -1);
    check("hit_nreq", n_rd_req, 0);
    check("hit_rdy_cycle", rd_rdy_cycle, 1);
    check("hit_rdy_cnt", rd_rdy_cnt, 1);
    check("hit_data", {32'd0, rd_dat}, 64'hDEADBEEF);

    // Write-through: request at cycle 1, ack at 3, ready at 4.
    op(1'b0, '0, 1'b1, 64'h100, 32'h55, 32'h0, 3, 2, -1);
    check("wr_nreq", n_wr_req, 1);
    check("wr_addr", wr_req_addr, 64'h100);
    check("wr_data", {32'd0, wr_req_data}, 64'h55);
    check("wr_rdy_cycle", wr_rdy_cycle, 4);
    check("wr_rdy_cnt", wr_rdy_cnt, 1);
    check("wr_no_rd", n_rd_req, 0);

    op(1'b1, 64'h100, 1'b0, '0, '0, 32'h0, 3, 0, -1);
    check("wr_then_hit_nreq", n_rd_req, 0);
    check("wr_then_hit_data", {32'd0, rd_dat}, 64'h55);

    // Conflict misses: 0x100 and 0x500 share index 0x40 with tags 0 and 1.
    pulse_reset();
    op(1'b1, 64'h100, 1'b0, '0, '0, 32'h55, 2, 0, -1);
    check("conf1_nreq", n_rd_req, 1);
    check("conf1_data", {32'd0, rd_dat}, 64'h55);
    op(1'b1, 64'h500, 1'b0, '0, '0, 32'hA5A50500, 2, 0, -1);
    check("conf2_nreq", n_rd_req, 1);
    check("conf2_addr", rd_req_addr, 64'h500);
    check("conf2_data", {32'd0, rd_dat}, 64'hA5A50500);
    op(1'b1, 64'h100, 1'b0, '0, '0, 32'h55, 2, 0, -1);
    check("conf3_nreq", n_rd_req, 1);
    check("conf3_data", {32'd0, rd_dat}, 64'h55);
    check("conf3_rdy_cycle", rd_rdy_cycle, 4);

    // Simultaneous write+read: write ready at 4, pending read hits at 5.
    op(1'b1, 64'h200, 1'b1, 64'h200, 32'h7, 32'h0, 3, 2, -1);
    check("sim_wr_rdy_cycle", wr_rdy_cycle, 4);
    check("sim_rd_rdy_cycle", rd_rdy_cycle, 5);
    check("sim_rd_data", {32'd0, rd_dat}, 64'h7);
    check("sim_no_rd_req", n_rd_req, 0);
    check("sim_rdy_cnts", {rd_rdy_cnt[31:0], wr_rdy_cnt[31:0]}, {32'd1, 32'd1});
`ifdef MEM_WORD_CACHE_STATS_EN
    check("stats_mid", {hit_count, miss_count}, {32'd1, 32'd3});
`else
    check("stats_mid", {hit_count, miss_count}, 64'd0);
`endif

    // Stray enable while waiting on memory, then reset mid-miss and a late valid.
    op(1'b1, 64'h300, 1'b0, '0, '0, 32'h0, 100, 0, 3);
    check("busy_nreq", n_rd_req, 1);
    check("busy_no_rdy", rd_rdy_cnt, 0);
    check("busy_proto_err", {63'd0, proto_err}, 64'd1);
    pulse_reset();
    check("rst2_proto_err", {63'd0, proto_err}, 64'd0);
    check("rst2_rd_data", {32'd0, up_read_data}, 64'd0);
    mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0BAD0;
    late_rdy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (up_read_ready != 64'd0) late_rdy++;
    end
    check("late_valid_no_rdy", late_rdy, 0);
    check("late_valid_no_req", {63'd0, mem_rd_req}, 64'd0);

    // 0x200 was cached before the reset; it must miss now.
    op(1'b1, 64'h200, 1'b0, '0, '0, 32'h7, 1, 0, -1);
    check("inval_nreq", n_rd_req, 1);
    check("inval_rdy_cycle", rd_rdy_cycle, 3);
    check("inval_data", {32'd0, rd_dat}, 64'h7);
`ifdef MEM_WORD_CACHE_STATS_EN
    check("stats_end", {hit_count, miss_count}, {32'd0, 32'd1});
`else
    check("stats_end", {hit_count, miss_count}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
